// File: rtl/sha_pkg.sv
// Shared types for the SHA-256 message path: block geometry, padded message
// container and the block scheduler state encoding.
package sha_pkg;
  localparam int BLOCK_W    = 512;
  localparam int MAX_BLOCKS = 4;

  typedef logic [BLOCK_W-1:0]                  block_t;
  typedef logic [MAX_BLOCKS-1:0][BLOCK_W-1:0]  padded_msg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREPROC,
    ST_ISSUE,
    ST_WAIT_CORE,
    ST_FINISH,
    ST_ERROR
  } sched_state_e;
endpackage

// File: rtl/sha_watchdog.sv
// Loadable up-counter with clear/enable; flags terminal count PRE_TIMEOUT-1
// and holds there until cleared or reloaded.
module sha_watchdog #(
  parameter int PRE_TIMEOUT = 400,
  parameter int CNT_W       = 9
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(PRE_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (load_i)             cnt_d = load_val_i;
    else if (en_i && cnt_q != TC) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC);
endmodule

// File: rtl/sha_block_scheduler.sv
// Sequences one message: kicks the preprocessor, latches its padded blocks,
// then feeds them highest index first to the compression core.
module sha_block_scheduler
  import sha_pkg::*;
#(
  parameter int PRE_TIMEOUT = 400,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        begin_preprocess,
  input  logic        pre_done,
  input  logic [1:0]  pre_position,
  input  padded_msg_t pre_msg,
  output logic        blk_valid,
  input  logic        blk_ready,
  output block_t      blk_data,
  output logic        blk_first,
  output logic        blk_last,
  input  logic        core_done,
  output logic        hash_done,
  output logic        busy,
  output logic        timeout_err
);
  sched_state_e state_q;
  padded_msg_t  msg_q;
  logic [1:0]   pos_q, idx_q, idx_dec;
  logic         begin_q, valid_q, first_q, last_q, done_q, busy_q, terr_q;
  block_t       data_q;
  logic         wd_clr, wd_en, wd_tc;

  assign wd_clr  = start && (state_q == ST_IDLE || state_q == ST_ERROR);
  assign wd_en   = (state_q == ST_PREPROC);
  assign idx_dec = idx_q - 2'd1;

  sha_watchdog #(.PRE_TIMEOUT(PRE_TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (wd_clr),
    .en_i       (wd_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      begin_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERROR: if (start) begin
          state_q <= ST_PREPROC;
          begin_q <= 1'b1;
          busy_q  <= 1'b1;
          terr_q  <= 1'b0;
        end
        // pre_done takes priority over an expiring watchdog
        ST_PREPROC: if (pre_done) begin
          state_q <= ST_ISSUE;
          msg_q   <= pre_msg;
          pos_q   <= pre_position;
          idx_q   <= pre_position;
          valid_q <= 1'b1;
          data_q  <= pre_msg[pre_position];
          first_q <= 1'b1;
          last_q  <= (pre_position == 2'd0);
        end else if (wd_tc) begin
          state_q <= ST_ERROR;
          busy_q  <= 1'b0;
          terr_q  <= 1'b1;
        end
        ST_ISSUE: if (blk_ready) begin
          state_q <= ST_WAIT_CORE;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
        end
        ST_WAIT_CORE: if (core_done) begin
          if (idx_q == 2'd0) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ISSUE;
            idx_q   <= idx_dec;
            valid_q <= 1'b1;
            data_q  <= msg_q[idx_dec];
            first_q <= (idx_dec == pos_q);
            last_q  <= (idx_dec == 2'd0);
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign begin_preprocess = begin_q;
  assign blk_valid        = valid_q;
  assign blk_data         = data_q;
  assign blk_first        = first_q;
  assign blk_last         = last_q;
  assign hash_done        = done_q;
  assign busy             = busy_q;
  assign timeout_err      = terr_q;
endmodule

// File: tb/tb_sha_block_scheduler.sv
// Self-checking bench: a negedge monitor records accepted blocks and pulses;
// each test compares them against the expected descending block order.
module tb_sha_block_scheduler;
  import sha_pkg::*;

  localparam int PRE_TIMEOUT = 400;
  localparam int CNT_W       = 9;

  logic        clk = 1'b0;
  logic        n_rst, start, pre_done, blk_ready, core_done;
  logic [1:0]  pre_position;
  padded_msg_t pre_msg;
  logic        begin_preprocess, blk_valid, blk_first, blk_last, hash_done, busy, timeout_err;
  block_t      blk_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha_block_scheduler #(.PRE_TIMEOUT(PRE_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .begin_preprocess (begin_preprocess),
    .pre_done         (pre_done),
    .pre_position     (pre_position),
    .pre_msg          (pre_msg),
    .blk_valid        (blk_valid),
    .blk_ready        (blk_ready),
    .blk_data         (blk_data),
    .blk_first        (blk_first),
    .blk_last         (blk_last),
    .core_done        (core_done),
    .hash_done        (hash_done),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  // Monitor: accepted blocks, pulse counts, and hold violations under backpressure
  block_t seen_data[$];
  bit     seen_first[$], seen_last[$];
  int     begin_cnt = 0, done_cnt = 0, unstable = 0;
  logic   pv = 1'b0, ph = 1'b0, pf, pl;
  block_t pd;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        if (begin_preprocess) begin_cnt++;
        if (hash_done) done_cnt++;
        if (pv && !ph && (!blk_valid || blk_data !== pd || blk_first !== pf || blk_last !== pl))
          unstable++;
        if (blk_valid && blk_ready) begin
          seen_data.push_back(blk_data);
          seen_first.push_back(blk_first);
          seen_last.push_back(blk_last);
        end
        pv = blk_valid;
        ph = blk_valid && blk_ready;
        pd = blk_data;
        pf = blk_first;
        pl = blk_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic padded_msg_t rand_msg();
    padded_msg_t m;
    for (int i = 0; i < MAX_BLOCKS; i++) m[i] = rand_block();
    return m;
  endfunction

  // Drives one complete hash; poke injects start in WAIT_CORE and core_done in ISSUE
  task automatic run_hash(input int pos, input padded_msg_t msg, input int pre_delay,
                          input int rdy_wait, input int core_wait, input bit poke,
                          output bit to);
    int g;
    to = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (pre_delay) tick();
    pre_msg = msg; pre_position = 2'(pos); pre_done = 1'b1; tick();
    pre_done = 1'b0; pre_msg = rand_msg(); pre_position = 2'($urandom);
    for (int b = 0; b <= pos; b++) begin
      g = 0;
      while (!blk_valid && g < 100) begin tick(); g++; end
      if (!blk_valid) begin to = 1'b1; return; end
      for (int w = 0; w < rdy_wait; w++) begin core_done = poke && (w == 0); tick(); end
      core_done = 1'b0;
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      for (int w = 0; w < core_wait; w++) begin
        start = poke && (w == 0); blk_ready = poke && (w == 0); tick();
      end
      start = 1'b0; blk_ready = 1'b0;
      core_done = 1'b1; tick(); core_done = 1'b0;
    end
    g = 0;
    while (busy && g < 100) begin tick(); g++; end
    if (busy) to = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 0; pre_done = 0; blk_ready = 0; core_done = 0;
    pre_position = 2'd3; pre_msg = rand_msg();
    tick(); tick();
    checks++;
    if ({begin_preprocess, blk_valid, blk_first, blk_last, hash_done, busy, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {begin_preprocess, blk_valid, blk_first, blk_last, hash_done, busy, timeout_err});
    end
    checks++;
    if (blk_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", blk_data); end
    n_rst = 1'b1; tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_block();
    padded_msg_t m = rand_msg();
    int q0 = seen_data.size(), d0 = done_cnt, b0 = begin_cnt;
    bit to;
    m[0] = {32'h61800000, 448'b0, 32'h00000008};
    run_hash(0, m, 315, 0, 4, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_run: got timeout 1 expected 0"); end
    checks++;
    if (seen_data.size() - q0 != 1 || (seen_data.size() > q0 && (seen_data[q0] !== m[0] || !seen_first[q0] || !seen_last[q0]))) begin
      errors++;
      $display("FAIL single_blk: got %0d blocks expected 1 with data %h first=1 last=1", seen_data.size() - q0, m[0]);
    end
    checks++;
    if (done_cnt - d0 != 1 || begin_cnt - b0 != 1) begin
      errors++;
      $display("FAIL single_pulses: got hash_done %0d begin %0d expected 1 1", done_cnt - d0, begin_cnt - b0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_two_blocks();
    padded_msg_t m = rand_msg();
    int q0 = seen_data.size(), d0 = done_cnt;
    bit to;
    m[1] = {32'h80000000, 480'b0};
    m[0] = {480'b0, 32'h00000200};
    run_hash(1, m, 20, 1, 3, 1'b0, to);
    checks++;
    if (to || seen_data.size() - q0 != 2) begin
      errors++; $display("FAIL two_count: got %0d blocks (timeout %0d) expected 2", seen_data.size() - q0, to);
    end
    for (int b = 0; b < 2 && q0 + b < seen_data.size(); b++) begin
      checks++;
      if (seen_data[q0+b] !== m[1-b] || seen_first[q0+b] !== (b == 0) || seen_last[q0+b] !== (b == 1)) begin
        errors++;
        $display("FAIL two_blk%0d: got first %0d last %0d data %h expected first %0d last %0d data %h",
                 b, seen_first[q0+b], seen_last[q0+b], seen_data[q0+b], b == 0, b == 1, m[1-b]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL two_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    padded_msg_t m = rand_msg();
    int q0 = seen_data.size(), u0 = unstable;
    bit to;
    run_hash(0, m, 10, 10, 2, 1'b0, to);
    checks++;
    if (unstable - u0 != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", unstable - u0); end
    checks++;
    if (to || seen_data.size() - q0 != 1 || (seen_data.size() > q0 && seen_data[q0] !== m[0])) begin
      errors++; $display("FAIL bp_transfer: got %0d transfers expected 1 of %h", seen_data.size() - q0, m[0]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (!timeout_err && n < PRE_TIMEOUT + 50) begin tick(); n++; end
    checks++;
    if (n != PRE_TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, PRE_TIMEOUT); end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_flags: got busy %b err %b expected 0 1", busy, timeout_err);
    end
    repeat (3) tick();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || begin_preprocess !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: got err %b begin %b busy %b expected 0 1 1", timeout_err, begin_preprocess, busy);
    end
    n_rst = 1'b0; tick(); n_rst = 1'b1; tick();
  endtask

  task automatic test_overlap();
    padded_msg_t m = rand_msg();
    int q0 = seen_data.size(), d0 = done_cnt, b0 = begin_cnt;
    bit to;
    run_hash(3, m, 8, 2, 3, 1'b1, to);
    checks++;
    if (to || seen_data.size() - q0 != 4 || begin_cnt - b0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL overlap_count: got blocks %0d begin %0d done %0d expected 4 1 1",
               seen_data.size() - q0, begin_cnt - b0, done_cnt - d0);
    end
    for (int b = 0; b < 4 && q0 + b < seen_data.size(); b++) begin
      checks++;
      if (seen_data[q0+b] !== m[3-b]) begin
        errors++; $display("FAIL overlap_order%0d: got %h expected %h", b, seen_data[q0+b], m[3-b]);
      end
    end
  endtask

  task automatic test_mid_reset();
    padded_msg_t m = rand_msg();
    int q0;
    bit to;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    pre_msg = m; pre_position = 2'd2; pre_done = 1'b1; tick(); pre_done = 1'b0;
    blk_ready = 1'b1; tick(); blk_ready = 1'b0;
    repeat (3) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    blk_ready = 1'b1; tick(); blk_ready = 1'b0;
    repeat (2) tick();
    n_rst = 1'b0; tick();
    checks++;
    if ({begin_preprocess, blk_valid, blk_first, blk_last, hash_done, busy, timeout_err} !== 7'b0 || blk_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b data %h expected 0000000 data 0",
               {begin_preprocess, blk_valid, blk_first, blk_last, hash_done, busy, timeout_err}, blk_data);
    end
    n_rst = 1'b1;
    core_done = 1'b1; tick(); core_done = 1'b0; tick();
    checks++;
    if (busy !== 1'b0 || blk_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got busy %b valid %b expected 0 0", busy, blk_valid);
    end
    m = rand_msg();
    q0 = seen_data.size();
    run_hash(2, m, 12, 0, 1, 1'b0, to);
    checks++;
    if (to || seen_data.size() - q0 != 3 || (seen_data.size() - q0 == 3 &&
        (seen_data[q0] !== m[2] || seen_data[q0+1] !== m[1] || seen_data[q0+2] !== m[0]))) begin
      errors++; $display("FAIL midrst_rerun: got %0d blocks (timeout %0d) expected 3 in order 2,1,0", seen_data.size() - q0, to);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      padded_msg_t m = rand_msg();
      int pos = $urandom_range(0, 3);
      int q0 = seen_data.size(), d0 = done_cnt;
      bit to;
      run_hash(pos, m, $urandom_range(0, 30), $urandom_range(0, 4), $urandom_range(0, 5), 1'($urandom), to);
      checks++;
      if (to || seen_data.size() - q0 != pos + 1 || done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL rand%0d_count: got blocks %0d done %0d expected %0d 1", it, seen_data.size() - q0, done_cnt - d0, pos + 1);
      end
      for (int b = 0; b <= pos && q0 + b < seen_data.size(); b++) begin
        checks++;
        if (seen_data[q0+b] !== m[pos-b] || seen_first[q0+b] !== (b == 0) || seen_last[q0+b] !== (b == pos)) begin
          errors++;
          $display("FAIL rand%0d_blk%0d: got first %0d last %0d data %h expected first %0d last %0d data %h",
                   it, b, seen_first[q0+b], seen_last[q0+b], seen_data[q0+b], b == 0, b == pos, m[pos-b]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_two_blocks();
    test_backpressure();
    test_timeout();
    test_overlap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
